// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request driver: select codes, flag bit positions, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    SelAnd  = 4'b0000,
    SelOr   = 4'b0001,
    SelNot  = 4'b0010,
    SelNor  = 4'b0011,
    SelXor  = 4'b0100,
    SelNand = 4'b0101,
    SelAdd  = 4'b0110,
    SelSub  = 4'b0111
  } alu_sel_e;

  localparam int unsigned FlagC = 3;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StResp   = 2'd2
  } drv_state_e;

  function automatic logic [3:0] pack_flags(input logic c, input logic n, input logic z,
                                            input logic v);
    logic [3:0] f;
    f        = '0;
    f[FlagC] = c;
    f[FlagN] = n;
    f[FlagZ] = z;
    f[FlagV] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_req_driver_if.sv
// Request, ALU-side and response signals of the ALU request driver.
interface alu_req_driver_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_sel;
  logic        req_cin;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic        alu_cin;
  logic [31:0] alu_y;
  logic        alu_cout;
  logic        alu_neg;
  logic        alu_zero;
  logic        alu_ovf;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic [3:0]  rsp_flags;

  // Driver view.
  modport master (
    input  req_valid, req_a, req_b, req_sel, req_cin,
    output req_ready,
    output alu_a, alu_b, alu_sel, alu_cin,
    input  alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
    output rsp_valid, rsp_y, rsp_flags,
    input  rsp_ready
  );

  // Command source / ALU / response consumer view.
  modport slave (
    output req_valid, req_a, req_b, req_sel, req_cin,
    input  req_ready,
    input  alu_a, alu_b, alu_sel, alu_cin,
    output alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
    input  rsp_valid, rsp_y, rsp_flags,
    output rsp_ready
  );

endinterface

// File: rtl/alu_settle_timer.sv
// Loadable down-counter; done_o is high while the count is zero.
module alu_settle_timer #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_req_driver.sv
// Sequential initiator for the combinational ALU: registers operands, waits for settling,
// then presents the captured result and flags as a valid/ready response.
module alu_req_driver
  import alu_pkg::*;
#(
  parameter int unsigned SettleCycles = 2,
  parameter int unsigned CntW         = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_req_driver_if.master     bus_io,
  input  logic                 clr_sticky_i,
  output logic                 ovf_sticky_o,
  output logic                 busy_o,
  output logic [CntW-1:0]      op_count_o
);

  localparam logic [3:0] SettleLoad = 4'(SettleCycles - 1);

  drv_state_e      state_q;
  logic [31:0]     alu_a_q, alu_b_q, rsp_y_q;
  logic [3:0]      alu_sel_q, rsp_flags_q;
  logic            alu_cin_q, rsp_valid_q, ovf_sticky_q;
  logic [CntW-1:0] op_count_q;

  logic req_ready, accept, capture, rsp_hs, timer_done;

  // In RESP the slot frees on the same edge the response is taken.
  assign req_ready = (state_q == StIdle) || ((state_q == StResp) && bus_io.rsp_ready);
  assign accept    = bus_io.req_valid && req_ready;
  assign capture   = (state_q == StSettle) && timer_done;
  assign rsp_hs    = rsp_valid_q && bus_io.rsp_ready;

  alu_settle_timer #(
    .CntW (4)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept),
    .load_val_i (SettleLoad),
    .done_o     (timer_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_y_q      <= '0;
      rsp_flags_q  <= '0;
      ovf_sticky_q <= 1'b0;
      op_count_q   <= '0;
    end else begin
      if (accept) begin
        alu_a_q   <= bus_io.req_a;
        alu_b_q   <= bus_io.req_b;
        alu_sel_q <= bus_io.req_sel;
        alu_cin_q <= bus_io.req_cin;
      end
      if (capture) begin
        rsp_y_q     <= bus_io.alu_y;
        rsp_flags_q <= pack_flags(bus_io.alu_cout, bus_io.alu_neg, bus_io.alu_zero,
                                  bus_io.alu_ovf);
      end

      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= StSettle;
        end
        StSettle: begin
          if (timer_done) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
          end
        end
        StResp: begin
          if (bus_io.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= bus_io.req_valid ? StSettle : StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
        end
      endcase

      // A capture with V=1 beats a coincident clear.
      if (capture && bus_io.alu_ovf) begin
        ovf_sticky_q <= 1'b1;
      end else if (clr_sticky_i) begin
        ovf_sticky_q <= 1'b0;
      end

      if (rsp_hs) op_count_q <= op_count_q + CntW'(1);
    end
  end

  assign bus_io.req_ready = req_ready;
  assign bus_io.alu_a     = alu_a_q;
  assign bus_io.alu_b     = alu_b_q;
  assign bus_io.alu_sel   = alu_sel_q;
  assign bus_io.alu_cin   = alu_cin_q;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_y     = rsp_y_q;
  assign bus_io.rsp_flags = rsp_flags_q;
  assign ovf_sticky_o     = ovf_sticky_q;
  assign busy_o           = (state_q != StIdle);
  assign op_count_o       = op_count_q;

endmodule

// File: tb/tb_alu_req_driver.sv
// Directed bench for alu_req_driver with a behavioural ALU on the alu_* side.
module tb_alu_req_driver;
  import alu_pkg::*;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr_sticky;
  logic            ovf_sticky;
  logic            busy;
  logic [CntW-1:0] op_count;
  int              n_cmp = 0;
  int              n_err = 0;
  int              cyc;

  alu_req_driver_if bus ();

  alu_req_driver #(
    .SettleCycles (2),
    .CntW         (CntW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus_io       (bus),
    .clr_sticky_i (clr_sticky),
    .ovf_sticky_o (ovf_sticky),
    .busy_o       (busy),
    .op_count_o   (op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU: logic ops leave C/V at 0; SUB is A + ~B + cin.
  logic [31:0] m_bop, m_y;
  logic [32:0] m_sum;
  logic        m_c, m_v;
  always_comb begin
    m_bop = (bus.alu_sel == SelSub) ? ~bus.alu_b : bus.alu_b;
    m_sum = {1'b0, bus.alu_a} + {1'b0, m_bop} + {32'd0, bus.alu_cin};
    m_y   = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (bus.alu_sel)
      SelAnd:  m_y = bus.alu_a & bus.alu_b;
      SelOr:   m_y = bus.alu_a | bus.alu_b;
      SelNot:  m_y = ~bus.alu_a;
      SelNor:  m_y = ~(bus.alu_a | bus.alu_b);
      SelXor:  m_y = bus.alu_a ^ bus.alu_b;
      SelNand: m_y = ~(bus.alu_a & bus.alu_b);
      SelAdd, SelSub: begin
        m_y = m_sum[31:0];
        m_c = m_sum[32];
        m_v = (bus.alu_a[31] == m_bop[31]) && (m_sum[31] != bus.alu_a[31]);
      end
      default: m_y = '0;
    endcase
    bus.alu_y    = m_y;
    bus.alu_cout = m_c;
    bus.alu_neg  = m_y[31];
    bus.alu_zero = (m_y == 32'd0);
    bus.alu_ovf  = m_v;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                       input logic cin);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sel   = sel;
    bus.req_cin   = cin;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Cycles from the accept edge until rsp_valid, capped at 20.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    clr_sticky    = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check1("rst_req_ready", bus.req_ready, 1'b1);
    check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_sticky", ovf_sticky, 1'b0);
    check("rst_alu_a", bus.alu_a, 32'h0);
    check("rst_rsp_y", bus.rsp_y, 32'h0);
    check("rst_op_count", 32'(op_count), 32'd0);
    rst           = 1'b0;
    bus.rsp_ready = 1'b1;

    // AND
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, SelAnd, 1'b0);
    check("and_alu_a", bus.alu_a, 32'hF0F0_F0F0);
    check1("and_busy", busy, 1'b1);
    check1("and_req_ready", bus.req_ready, 1'b0);
    wait_rsp(cyc);
    check("and_latency", 32'(cyc), 32'd2);
    check("and_y", bus.rsp_y, 32'hF000_F000);
    check("and_flags", 32'(bus.rsp_flags), 32'b0100);
    tick();
    check("and_op_count", 32'(op_count), 32'd1);
    check1("and_rsp_done", bus.rsp_valid, 1'b0);
    check1("and_idle", busy, 1'b0);

    // ADD overflow and sticky flag
    issue(32'h7FFF_FFFF, 32'h0000_0001, SelAdd, 1'b0);
    wait_rsp(cyc);
    check("add_latency", 32'(cyc), 32'd2);
    check("add_y", bus.rsp_y, 32'h8000_0000);
    check("add_flags", 32'(bus.rsp_flags), 32'b0101);
    check1("add_sticky", ovf_sticky, 1'b1);
    tick();
    tick();
    tick();
    check1("add_sticky_hold", ovf_sticky, 1'b1);
    check("add_op_count", 32'(op_count), 32'd2);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check1("add_sticky_clr", ovf_sticky, 1'b0);

    // SUB to zero
    issue(32'd5, 32'd5, SelSub, 1'b1);
    wait_rsp(cyc);
    check("sub_y", bus.rsp_y, 32'h0);
    check("sub_flags", 32'(bus.rsp_flags), 32'b1010);
    check1("sub_sticky", ovf_sticky, 1'b0);
    tick();
    check("sub_op_count", 32'(op_count), 32'd3);

    // Backpressure with a pending request that must not be taken early
    bus.rsp_ready = 1'b0;
    issue(32'h1234_5678, 32'h0F0F_0F0F, SelXor, 1'b0);
    wait_rsp(cyc);
    check("bp_y", bus.rsp_y, 32'h1D3B_5977);
    check("bp_flags", 32'(bus.rsp_flags), 32'b0000);
    bus.req_a     = 32'h00FF_0000;
    bus.req_b     = 32'h0000_FF00;
    bus.req_sel   = SelOr;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_y", bus.rsp_y, 32'h1D3B_5977);
      check("bp_hold_flags", 32'(bus.rsp_flags), 32'b0000);
      check1("bp_req_ready", bus.req_ready, 1'b0);
      check1("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_alu_a_hold", bus.alu_a, 32'h1234_5678);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("bp_op_count", 32'(op_count), 32'd4);
    check1("bp_busy", busy, 1'b1);
    check1("bp_rsp_valid_lo", bus.rsp_valid, 1'b0);
    check("bp_alu_a_new", bus.alu_a, 32'h00FF_0000);
    wait_rsp(cyc);
    check("bp_latency", 32'(cyc), 32'd2);
    check("or_y", bus.rsp_y, 32'h00FF_FF00);
    tick();
    check("or_op_count", 32'(op_count), 32'd5);

    // Reset during SETTLE discards the operation
    issue(32'd3, 32'd4, SelAdd, 1'b0);
    rst = 1'b1;
    tick();
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check1("mid_rst_req_ready", bus.req_ready, 1'b1);
    check("mid_rst_alu_a", bus.alu_a, 32'h0);
    check("mid_rst_rsp_y", bus.rsp_y, 32'h0);
    check("mid_rst_op_count", 32'(op_count), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("mid_rst_no_rsp", bus.rsp_valid, 1'b0);
    end
    check("mid_rst_count_hold", 32'(op_count), 32'd0);

    // 17 back-to-back ops: counter wraps, last capture has V=1 under a clear
    bus.req_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus.req_a   = (k == 16) ? 32'h7FFF_FFFF : 32'(k);
      bus.req_b   = (k == 16) ? 32'h0000_0001 : 32'h0000_0100;
      bus.req_sel = SelAdd;
      bus.req_cin = 1'b0;
      tick();
      tick();
      if (k == 16) clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check1("b2b_rsp_valid", bus.rsp_valid, 1'b1);
      check("b2b_y", bus.rsp_y, (k == 16) ? 32'h8000_0000 : 32'(k) + 32'h100);
      check1("b2b_sticky", ovf_sticky, (k == 16));
      if (k == 16) begin
        check("b2b_wrap_zero", 32'(op_count), 32'd0);
        bus.req_valid = 1'b0;
      end
    end
    tick();
    check("b2b_op_count", 32'(op_count), 32'd1);
    check1("b2b_idle", busy, 1'b0);
    check1("b2b_sticky_keep", ovf_sticky, 1'b1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check1("b2b_sticky_clr", ovf_sticky, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
